fft_sdf_stage_ctrl: RTL and testbench

Synchronous sequencer for one radix-2 single-path delay-feedback FFT stage. Drives write and read enables of the stage's delay FIFO (depth 2^DEPTH_LOG2) from the input valid stream. Each block of 2·DEPTH samples splits into a FILL half (samples written) and a PAIR half (FIFO read as x1, live sample as x2). Produces the butterfly pair-valid strobe and twiddle ROM address, and resynchronises FIFO and counters on misaligned frame starts or FIFO status faults. It replaces edge-triggered full/empty enable logic with counter-based control on the stage clock.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_sdf_stage_ctrl.sv | 147 ++++++++++++++
 tb/tb_fft_sdf_stage_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the SDF FFT stage sequencer
//
// Purpose : state encoding for the stage sequencer, the datapath word width
//           and the twiddle-address scaling helper.
// Contents: state_t   - SYNC / FILL / PAIR
//           FLOAT_LEN - datapath sample word width
//           tf_shift  - scales a pair index into the twiddle ROM address space

package fft_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_FILL = 2'd1,
    ST_PAIR = 2'd2
  } state_t;

  localparam int FLOAT_LEN = 32;

  // The twiddle ROM is sized for the largest stage; smaller stages step
  // through it with a stride of 2^(TF_ADDR_LEN - DEPTH_LOG2).
  function automatic logic [FLOAT_LEN-1:0] tf_shift(input logic [FLOAT_LEN-1:0] k,
                                                    input int                   sh);
    return k << sh;
  endfunction

endpackage

// File: rtl/fft_sdf_stage_ctrl.sv
// rtl/fft_sdf_stage_ctrl.sv - sequencer for one radix-2 single-path delay-feedback FFT stage
//
// Purpose : counts valid input samples into blocks of 2*DEPTH. The first half
//           (FILL) is written into the delay FIFO, the second half (PAIR) reads
//           the FIFO as x1 while the live sample becomes x2. Misaligned frame
//           starts and FIFO status faults flush the FIFO and resynchronise.
// Ports   : clk, rst            - stage clock, asynchronous active-high reset
//           data_in_valid/sop   - input sample qualifier and frame start
//           fifo_full/empty     - delay FIFO status
//           fifo_wr_en/rd_en    - combinational FIFO strobes, same cycle as sample
//           fifo_flush          - registered one-cycle FIFO clear
//           pair_valid, tf_addr - registered butterfly strobe and twiddle address
//           block_done          - registered, with the last pair of a block
//           err                 - registered one-cycle fault pulse

import fft_pkg::*;

module fft_sdf_stage_ctrl #(
  parameter int DEPTH_LOG2  = 5,
  parameter int TF_ADDR_LEN = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_in_valid,
  input  logic                   data_in_sop,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   fifo_wr_en,
  output logic                   fifo_rd_en,
  output logic                   fifo_flush,
  output logic                   pair_valid,
  output logic [TF_ADDR_LEN-1:0] tf_addr,
  output logic                   block_done,
  output logic                   err
);

  localparam logic [DEPTH_LOG2-1:0] CNT_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] CNT_LAST = '1;
  localparam int                    TF_SH    = TF_ADDR_LEN - DEPTH_LOG2;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DEPTH_LOG2-1:0]  r_cnt;
  logic [DEPTH_LOG2-1:0]  w_cnt_nxt;
  logic [DEPTH_LOG2-1:0]  w_cnt_inc;
  logic                   w_last;
  logic                   w_wr_en;
  logic                   w_rd_en;
  logic                   w_fault;
  logic [TF_ADDR_LEN-1:0] w_tf_addr;

  logic                   r_pair_valid;
  logic [TF_ADDR_LEN-1:0] r_tf_addr;
  logic                   r_block_done;
  logic                   r_err;
  logic                   r_flush;

  assign w_cnt_inc = r_cnt + CNT_ONE;
  assign w_last    = (r_cnt == CNT_LAST);
  assign w_tf_addr = TF_ADDR_LEN'(tf_shift(FLOAT_LEN'(r_cnt), TF_SH));

  // Next state, counter and strobes. Nothing moves without data_in_valid.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_fault     = 1'b0;
    if (data_in_valid) begin
      case (r_state)
        ST_SYNC: begin
          // Samples before the first frame start are dropped silently.
          if (data_in_sop) begin
            w_wr_en     = 1'b1;
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = ST_FILL;
          end
        end
        ST_FILL: begin
          // sop is only legal as the first sample of a FILL half.
          if ((data_in_sop && (r_cnt != '0)) || fifo_full) begin
            w_fault = 1'b1;
          end else begin
            w_wr_en   = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            if (w_last) w_state_nxt = ST_PAIR;
          end
        end
        ST_PAIR: begin
          if (data_in_sop || fifo_empty) begin
            w_fault = 1'b1;
          end else begin
            w_rd_en   = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            if (w_last) w_state_nxt = ST_FILL;
          end
        end
        default: begin
          w_state_nxt = ST_SYNC;
          w_cnt_nxt   = '0;
        end
      endcase
    end
    if (w_fault) begin
      w_state_nxt = ST_SYNC;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SYNC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // One-cycle delay matches the FIFO read latency and the x2 input register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair_valid <= 1'b0;
      r_tf_addr    <= '0;
      r_block_done <= 1'b0;
      r_err        <= 1'b0;
      r_flush      <= 1'b0;
    end else begin
      r_pair_valid <= w_rd_en;
      if (w_rd_en) r_tf_addr <= w_tf_addr;
      r_block_done <= w_rd_en && w_last;
      r_err        <= w_fault;
      r_flush      <= w_fault;
    end
  end

  // Strobes are forced low while reset is held so the FIFO sees no access
  // in the reset cycle even if a sop arrives with it.
  assign fifo_wr_en = w_wr_en && !rst;
  assign fifo_rd_en = w_rd_en && !rst;
  assign fifo_flush = r_flush;
  assign pair_valid = r_pair_valid;
  assign tf_addr    = r_tf_addr;
  assign block_done = r_block_done;
  assign err        = r_err;

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// tb/tb_fft_sdf_stage_ctrl.sv - self-checking bench for fft_sdf_stage_ctrl

module tb_fft_sdf_stage_ctrl;

  localparam int DL  = 2;
  localparam int D   = 4;
  localparam int TFA = 5;
  localparam int SH  = TFA - DL;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           data_in_valid = 1'b0;
  logic           data_in_sop = 1'b0;
  logic           fifo_full = 1'b0;
  logic           fifo_empty = 1'b0;
  logic           fifo_wr_en, fifo_rd_en, fifo_flush, pair_valid, block_done, err;
  logic [TFA-1:0] tf_addr;

  fft_sdf_stage_ctrl #(.DEPTH_LOG2(DL), .TF_ADDR_LEN(TFA)) dut (
    .clk(clk), .rst(rst),
    .data_in_valid(data_in_valid), .data_in_sop(data_in_sop),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_flush(fifo_flush),
    .pair_valid(pair_valid), .tf_addr(tf_addr), .block_done(block_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: position p within the 2*D sample block; first half
  // writes, second half reads pair index p-D.
  bit             m_sync = 0;
  int             m_p = 0;
  bit             e_pv = 0, e_bd = 0, e_err = 0, e_flush = 0;
  logic [TFA-1:0] e_tf = '0;

  task automatic step(input bit v, input bit s, input bit f, input bit e, input bit r);
    bit fill, bad, xwr, xrd;
    @(negedge clk);
    rst = r; data_in_valid = v; data_in_sop = s; fifo_full = f; fifo_empty = e;
    #1;
    if (r) begin
      m_sync = 0; m_p = 0;
      e_pv = 0; e_bd = 0; e_err = 0; e_flush = 0; e_tf = '0;
    end
    xwr = 0; xrd = 0; bad = 0; fill = 0;
    if (!r) begin
      if (!m_sync) xwr = v && s;
      else begin
        fill = (m_p < D);
        bad  = v && ((s && !(fill && m_p == 0)) || (fill ? f : e));
        xwr  = fill && v && !bad;
        xrd  = !fill && v && !bad;
      end
    end
    chk("wr_en", fifo_wr_en, xwr);
    chk("rd_en", fifo_rd_en, xrd);
    chk("pair_valid", pair_valid, e_pv);
    chk("tf_addr", tf_addr, e_tf);
    chk("block_done", block_done, e_bd);
    chk("err", err, e_err);
    chk("fifo_flush", fifo_flush, e_flush);
    if (!r) begin
      e_pv = xrd;
      if (xrd) e_tf = TFA'((m_p - D) << SH);
      e_bd = xrd && (m_p == 2*D - 1);
      e_err = bad;
      e_flush = bad;
      if (!m_sync) begin
        if (v && s) begin m_sync = 1; m_p = 1; end
      end else if (v) begin
        if (bad) begin m_sync = 0; m_p = 0; end
        else m_p = (m_p + 1) % (2*D);
      end
    end
  endtask

  typedef struct {
    bit             v, s;
    bit             wr, rd, pv, bd, er;
    logic [TFA-1:0] tf;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int tfr, npv, nbd;
    // Table: 3 samples without sop, then the 16-sample continuous block pair.
    tfr = 0;
    for (int i = 0; i < 3; i++)
      tbl[i] = '{v:1'b1, s:1'b0, wr:1'b0, rd:1'b0, pv:1'b0, bd:1'b0, er:1'b0, tf:'0};
    for (int c = 0; c < 18; c++) begin
      bit pv;
      pv = (c >= 5 && c <= 8) || (c >= 13 && c <= 16);
      if (pv) tfr = ((c - 5) % 4) * 8;
      tbl[3+c] = '{v:(c < 16), s:(c == 0),
                   wr:((c < 4) || (c >= 8 && c < 12)),
                   rd:((c >= 4 && c < 8) || (c >= 12 && c < 16)),
                   pv:pv, bd:(c == 8 || c == 16), er:1'b0, tf:TFA'(tfr)};
    end

    // Reset state, with a sop presented while reset is held.
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rst = 0; data_in_valid = tbl[i].v; data_in_sop = tbl[i].s;
      fifo_full = 0; fifo_empty = 0;
      #1;
      chk("tbl_wr_en", fifo_wr_en, tbl[i].wr);
      chk("tbl_rd_en", fifo_rd_en, tbl[i].rd);
      chk("tbl_pair_valid", pair_valid, tbl[i].pv);
      chk("tbl_tf_addr", tf_addr, tbl[i].tf);
      chk("tbl_block_done", block_done, tbl[i].bd);
      chk("tbl_err", err, tbl[i].er);
      chk("tbl_flush", fifo_flush, tbl[i].er);
    end

    // Valid on every other cycle: same sequences, stretched.
    step(0, 0, 0, 0, 1);
    npv = 0; nbd = 0;
    for (int i = 0; i < 34; i++) begin
      step(i % 2 == 0 && i < 32, i == 0, 0, 0, 0);
      npv += int'(pair_valid);
      nbd += int'(block_done);
    end
    chk("gap_pair_count", npv, 8);
    chk("gap_done_count", nbd, 2);

    // Misaligned sop at FILL index 2.
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("misalign_no_write", fifo_wr_en, 0);
    step(1, 0, 0, 0, 0);
    chk("misalign_err", err, 1);
    chk("misalign_flush", fifo_flush, 1);
    chk("misalign_sync_drop", fifo_wr_en, 0);
    npv = 0;
    for (int i = 0; i < 10; i++) begin
      step(i < 8, i == 0, 0, 0, 0);
      npv += int'(pair_valid);
    end
    chk("misalign_recover_pairs", npv, 4);

    // FIFO empty during PAIR.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, i == 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("empty_no_read", fifo_rd_en, 0);
    step(0, 0, 0, 0, 0);
    chk("empty_err", err, 1);
    chk("empty_flush", fifo_flush, 1);
    for (int i = 0; i < 10; i++) step(i < 8, i == 0, 0, 0, 0);

    // Reset mid-PAIR, then samples without sop must produce nothing.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, i == 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_pair_valid", pair_valid, 0);
    chk("rst_tf_addr", tf_addr, 0);
    npv = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0);
      npv += int'(pair_valid) + int'(fifo_wr_en) + int'(fifo_rd_en);
    end
    chk("rst_nosop_quiet", npv, 0);
    for (int i = 0; i < 10; i++) step(i < 8, i == 0, 0, 0, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 23) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 499) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
